// File: rtl/minirisc_pkg.sv
// Shared miniRISC definitions: instruction width, instruction-memory depth
// and the program-loader FSM state encoding.
package minirisc_pkg;

  localparam int INSTR_W     = 32;
  localparam int IMEM_ADDR_W = 10;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_CHECK,
    LD_DONE
  } loader_state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// Big-endian byte packer: shifts accepted bytes into a word register and flags
// the byte that completes a word. word is the packed value including that byte.
module loader_byte_packer
  import minirisc_pkg::*;
#(
  parameter int DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              take,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  count;

  // Older bytes move toward the MSB, so the first byte of a word ends up on top.
  assign word       = DATA_W'({shift, byte_in});
  assign word_valid = take && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      shift <= '0;
      count <= '0;
    end else if (take) begin
      shift <= word;
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// miniRISC instruction-memory loader: packs a byte stream into words, writes them
// from address 0 and holds the core in reset until done. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import minirisc_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  loader_state_t     state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcount;
  logic [ADDR_W:0]   wcount_next;
  logic              take;
  logic              start_go;
  logic              word_valid;
  logic [DATA_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  assign take        = in_valid && in_ready;
  assign start_go    = start && ((state == LD_IDLE) || (state == LD_DONE));
  assign wcount_next = wcount + 1'b1;

  loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_go),
    .take       (take),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= LD_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_q      <= '0;
      wcount     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            len_q      <= len;
            wcount     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc        <= '0;
`endif
            if (len != '0) begin
              state    <= LD_RECV;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= LD_CHECK;
              busy     <= 1'b1;
              in_ready <= 1'b1;
`else
              state      <= LD_DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
`endif
            end
          end
        end

        LD_RECV: begin
          if (word_valid) begin
            state      <= LD_WRITE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b1;
            imem_wdata <= word;
            imem_addr  <= wcount[ADDR_W-1:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc        <= acc ^ word;
`endif
          end
        end

        // A load longer than the memory stops at the top address instead of wrapping.
        LD_WRITE: begin
          wcount <= wcount_next;
          if (wcount_next == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= LD_CHECK;
            in_ready <= 1'b1;
`else
            state      <= LD_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            core_rst_n <= 1'b1;
`endif
          end else if (wcount == LAST_ADDR) begin
            state      <= LD_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            err        <= 1'b1;
            core_rst_n <= 1'b0;
          end else begin
            state    <= LD_RECV;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        LD_CHECK: begin
          if (word_valid) begin
            state      <= LD_DONE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            err        <= (word != acc);
            core_rst_n <= (word == acc);
          end
        end
`endif

        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule
